// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter
// Packet-granular round-robin arbiter that shares one NoC node local
// injection port among NUM_REQ requesters. The grant is held from header
// to tail so wormhole packets are never interleaved. The output is one
// registered flit stage that sustains one flit per cycle.
//
// Handshake: a flit moves on any interface when valid & ready are both high
// at a rising clock edge. Valid and its payload must stay stable until that
// edge. Ready may depend on valid within the same cycle.
//
// Ports:
//   noc_clk, noc_rst    clock, synchronous active-high reset
//   req_valid/ready     per-requester flit handshake
//   req_flit            packed flits, requester i at [i*FLIT_W +: FLIT_W]
//   req_is_header/tail  per-requester framing flags
//   out_valid/ready     handshake toward the node receive port
//   out_flit            registered flit toward the node
//   out_is_header/tail  registered framing flags
//   owner               current or last granted requester
//   busy                high while a multi-flit packet holds the grant
//   pkt_cnt             tails delivered on the output, wraps
//   proto_err           sticky protocol-error flag
module noc_inject_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int FLIT_W  = 32,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
  input  logic [NUM_REQ-1:0]        req_is_header,
  input  logic [NUM_REQ-1:0]        req_is_tail,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FLIT_W-1:0]         out_flit,
  output logic                      out_is_header,
  output logic                      out_is_tail,
  output logic [IDX_W-1:0]          owner,
  output logic                      busy,
  output logic [CNT_W-1:0]          pkt_cnt,
  output logic                      proto_err
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;

  logic             load_en;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  int               cand;
  logic [IDX_W-1:0] sel;
  logic             grant_ok;
  logic             xfer;
  logic [FLIT_W-1:0] sel_flit;
  logic             sel_hdr;
  logic             sel_tail;
  logic             bad_in_idle;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  assign load_en = !out_valid || out_ready;
  assign busy    = (state == LOCKED);

  // First header-bearing requester at or after rr_ptr, wrapping upward.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_found && req_valid[cand] && req_is_header[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  assign sel      = busy ? owner : win_idx;
  assign grant_ok = busy || win_found;

  // Only one ready bit can ever be high, and none while in reset or while
  // the output register is full and stalled.
  assign req_ready = (!noc_rst && grant_ok && load_en) ?
                     (NUM_REQ'(1) << sel) : '0;

  assign xfer     = req_valid[sel] && req_ready[sel];
  assign sel_flit = req_flit[int'(sel)*FLIT_W +: FLIT_W];
  assign sel_hdr  = req_is_header[sel];
  assign sel_tail = req_is_tail[sel];

  // A body/tail flit offered with nobody holding the grant is a framing error.
  assign bad_in_idle = !busy && |(req_valid & ~req_is_header);

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      out_valid     <= 1'b0;
      out_flit      <= '0;
      out_is_header <= 1'b0;
      out_is_tail   <= 1'b0;
      pkt_cnt       <= '0;
      proto_err     <= 1'b0;
    end else begin
      if (out_valid && out_ready && out_is_tail)
        pkt_cnt <= pkt_cnt + 1'b1;

      if (bad_in_idle)
        proto_err <= 1'b1;

      if (xfer) begin
        out_valid     <= 1'b1;
        out_flit      <= sel_flit;
        out_is_header <= sel_hdr;
        out_is_tail   <= sel_tail;
        case (state)
          IDLE: begin
            owner <= win_idx;
            if (sel_tail) rr_ptr <= next_idx(win_idx);
            else          state  <= LOCKED;
          end
          LOCKED: begin
            // A repeated header inside a packet is still forwarded.
            if (sel_hdr) proto_err <= 1'b1;
            if (sel_tail) begin
              state  <= IDLE;
              rr_ptr <= next_idx(owner);
            end
          end
          default: state <= IDLE;
        endcase
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
